// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates one single-ported word memory between an instruction-fetch port
// and a data (load/store) port. Exactly one access is in flight at a time;
// the FSM walks IDLE -> ACCESS -> IDLE. The data port has priority over fetch.
//
// Timing (grant at rising edge N):
//   edge N          : winner's gnt, mem_en, mem_we and mem_addr/mem_wdata go out
//   edge N+MEM_LAT  : mem_rdata captured into rdata (loads and fetches only),
//                     winner's valid pulses, FSM returns to IDLE
//   edge N+MEM_LAT+1: earliest next grant
//
// Optional build feature (macro MEM_ARB_STARVE_GUARD_EN):
//   Adds parameter STARVE_MAX and a counter of consecutive IDLE arbitrations
//   that a pending fetch lost to the data port. Once the counter reaches
//   STARVE_MAX, the next arbitration goes to fetch. The counter clears on a
//   fetch grant or on any arbitration taken while if_req is low. Without the
//   macro the priority is strictly data over fetch.
//
// Parameters:
//   AW          memory word-address width
//   DW          data word width
//   MEM_LAT     memory read latency in cycles, legal range 1..4
//   STARVE_MAX  (guard build only) data wins tolerated before fetch is forced
//
// Ports:
//   clk1, rst_n                 clock, asynchronous active-low reset
//   if_req, if_addr             fetch request (held until if_gnt) and address
//   if_gnt, if_valid            fetch accepted / fetched word on rdata
//   d_req, d_we, d_addr, d_wdata data request (held until d_gnt), store flag,
//                               address and store data
//   d_gnt, d_valid              data accepted / load data on rdata or store done
//   rdata                       read data for whichever port pulses valid
//   mem_en, mem_we              one-cycle access strobe and its write enable
//   mem_addr, mem_wdata         access address / store data, held per access
//   mem_rdata                   memory read data, sampled MEM_LAT edges on
//   busy                        high while an access is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic          clk1,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  // shared read return
  output logic [DW-1:0] rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy
);

  // The latency counter only has to reach MEM_LAT-1, at most 3.
  localparam int              CW       = 2;
  localparam logic [CW-1:0]   LAST_CNT = CW'(MEM_LAT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc_data;   // access in flight belongs to the data port
  logic          acc_store;  // access in flight is a store: rdata untouched
  logic          any_req;
  logic          grant_data; // arbitration outcome, meaningful only in IDLE

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Wide enough to hold STARVE_MAX itself; the +2 keeps the width >= 1.
  localparam int SW = $clog2(STARVE_MAX + 2);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt >= SW'(STARVE_MAX));

  // A starved fetch overrides the data port for exactly one arbitration.
  assign grant_data = d_req & ~(if_req & starved);

  // Only IDLE arbitrations count. A lost fetch bumps the counter; a fetch
  // grant or an arbitration without a pending fetch clears it. Saturation is
  // implicit: once starved with if_req high, fetch wins and the count clears.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (if_req && grant_data) begin
        starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign grant_data = d_req;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is clocked state, so it takes non-blocking
  // assignments; blocking ones would let later statements in this block see
  // next-cycle values and break the register semantics.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the block holds no storage array, so every register, datapath
      // included, gets a defined reset value at no real cost.
      state     <= IDLE;
      cnt       <= '0;
      acc_data  <= 1'b0;
      acc_store <= 1'b0;
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only on the
      // edge that owns them, which keeps each strobe exactly one cycle wide.
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (any_req) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            cnt    <= '0;
            mem_en <= 1'b1;
            if (grant_data) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              acc_data  <= 1'b1;
              acc_store <= d_we;
            end else begin
              // Fetch is a read; mem_wdata is irrelevant and left alone.
              if_gnt    <= 1'b1;
              mem_addr  <= if_addr;
              acc_data  <= 1'b0;
              acc_store <= 1'b0;
            end
          end
        end

        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            // A store reports completion only; rdata keeps the last load.
            if (!acc_store) begin
              rdata <= mem_rdata;
            end
            if (acc_data) begin
              d_valid <= 1'b1;
            end else begin
              if_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two instances: dut (MEM_LAT=3) carries the scoreboarded traffic, dut1
// (MEM_LAT=1) is used for a short directed fetch with fixed expected values.
// The reference model tracks "free / busy until edge X", applies the priority
// rule (and the starvation rule when MEM_ARB_STARVE_GUARD_EN is defined),
// keeps a shadow memory, and pushes expected responses into a queue that a
// separate monitor pops whenever the DUT pulses a valid.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int LAT        = 3;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << AW;

  logic          clk1 = 1'b0;
  logic          rst_n;

  // main instance
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_valid, d_gnt, d_valid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // latency-1 instance
  logic          s_if_req, s_d_req, s_d_we;
  logic [AW-1:0] s_if_addr, s_d_addr;
  logic [DW-1:0] s_d_wdata;
  logic          s_if_gnt, s_if_valid, s_d_gnt, s_d_valid;
  logic [DW-1:0] s_rdata;
  logic          s_mem_en, s_mem_we, s_busy;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata, s_mem_rdata;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT)
`ifdef MEM_ARB_STARVE_GUARD_EN
    , .STARVE_MAX(STARVE_MAX)
`endif
  ) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(1)
`ifdef MEM_ARB_STARVE_GUARD_EN
    , .STARVE_MAX(STARVE_MAX)
`endif
  ) dut1 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(s_if_req), .if_addr(s_if_addr), .if_gnt(s_if_gnt), .if_valid(s_if_valid),
    .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
    .d_gnt(s_d_gnt), .d_valid(s_d_valid), .rdata(s_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .busy(s_busy)
  );

  // Latency-1 memory: combinational, one known word.
  assign s_mem_rdata = (s_mem_addr == 10'h005) ? 32'h2801_000A : 32'h0;

  // ---------------------------------------------------------------------------
  // Bookkeeping and check helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory attached to the main instance: reads combinational on the held
  // address, writes on the edge that closes the mem_en cycle.
  logic [DW-1:0] dmem [DEPTH];
  assign mem_rdata = dmem[mem_addr];

  initial begin
    for (int i = 0; i < DEPTH; i++) dmem[i] = init_val(i);
    forever begin
      @(posedge clk1);
      if (mem_en && mem_we) dmem[mem_addr] = mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: arbitration, timing, shadow memory, expected responses
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            is_data;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            edge_n  = 0;
  bit            m_idle  = 1'b1;
  int            m_done  = 0;
  int            m_starve = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            take_d;
  bit            e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_store;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk1);
      edge_n++;
      e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_mem_en = 1'b0; e_mem_we = 1'b0; e_store = 1'b0;
      if (!rst_n) begin
        m_idle = 1'b1; m_starve = 0; m_rdata = '0; sb_q.delete();
        e_addr = '0; e_wdata = '0;
      end else if (m_idle) begin
        if (if_req || d_req) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
          take_d = d_req && !(if_req && m_starve >= STARVE_MAX);
          if (if_req && take_d) m_starve++;
          else m_starve = 0;
`else
          take_d = d_req;
`endif
          e_mem_en = 1'b1;
          if (take_d) begin
            e_d_gnt  = 1'b1;
            e_mem_we = d_we;
            e_addr   = d_addr;
            if (d_we) begin
              e_store = 1'b1;
              e_wdata = d_wdata;
              ref_mem[d_addr] = d_wdata;
            end else begin
              m_rdata = ref_mem[d_addr];
            end
            sb_q.push_back('{is_data: 1'b1, data: m_rdata, due: edge_n + LAT});
          end else begin
            e_if_gnt = 1'b1;
            e_addr   = if_addr;
            m_rdata  = ref_mem[if_addr];
            sb_q.push_back('{is_data: 1'b0, data: m_rdata, due: edge_n + LAT});
          end
          m_idle = 1'b0;
          m_done = edge_n + LAT;
        end
      end else if (edge_n == m_done) begin
        m_idle = 1'b1;
      end

      #1;
      check("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
      check("d_gnt",  64'(d_gnt),  64'(e_d_gnt));
      check("mem_en", 64'(mem_en), 64'(e_mem_en));
      check("mem_we", 64'(mem_we), 64'(e_mem_we));
      check("busy",   64'(busy),   64'(!m_idle));
      if (!rst_n || !m_idle) check("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (!rst_n || e_store) check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor: pops an expectation whenever a valid appears.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] last_rdata = '0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk1);
      #1;
      if (!rst_n) begin
        last_rdata = '0;
        check("rst_valid", 64'({if_valid, d_valid}), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
      end else if (if_valid || d_valid) begin
        if (if_valid && d_valid) fail("both_valid", "if_valid and d_valid high together");
        if (sb_q.size() == 0) begin
          fail("spurious_valid", "valid pulse with no access outstanding");
        end else begin
          e = sb_q.pop_front();
          check("valid_port", 64'(d_valid), 64'(e.is_data));
          check("valid_edge", 64'(edge_n), 64'(e.due));
          check("rdata", 64'(rdata), 64'(e.data));
          last_rdata = e.data;
        end
      end else begin
        if (sb_q.size() != 0 && sb_q[0].due <= edge_n) begin
          fail("missing_valid", "expected valid did not arrive");
          void'(sb_q.pop_front());
        end
        check("rdata_hold", 64'(rdata), 64'(last_rdata));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester driver: everything changes on the falling edge.
  // ---------------------------------------------------------------------------
  bit rand_en = 1'b0;
  bit d_hold  = 1'b0;
  int if_wait = 0, d_wait = 0;
  int if_grants = 0, d_grants = 0, first_if_at = -1;

  task automatic step();
    @(negedge clk1);
    if (if_req && if_gnt) begin
      if (if_grants == 0) first_if_at = d_grants;
      if_req = 1'b0; if_wait = 0; if_grants++;
    end
    if (d_req && d_gnt) begin
      d_req = 1'b0; d_wait = 0; d_grants++;
    end
    if (if_req && ++if_wait > 400) begin
      fail("if_timeout", "fetch request never granted");
      if_req = 1'b0; if_wait = 0;
    end
    if (d_req && ++d_wait > 400) begin
      fail("d_timeout", "data request never granted");
      d_req = 1'b0; d_wait = 0;
    end
    if (d_hold && !d_req) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = AW'($urandom_range(0, 31));
    end
    if (rand_en) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(0, 31));
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 31)); d_wdata = $urandom;
      end
    end
  endtask

  task automatic wait_if_free();
    for (int i = 0; i < 500 && if_req; i++) step();
  endtask

  task automatic wait_d_free();
    for (int i = 0; i < 500 && d_req; i++) step();
  endtask

  task automatic issue_fetch(input logic [AW-1:0] a);
    wait_if_free();
    if_addr = a; if_req = 1'b1;
  endtask

  task automatic issue_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    wait_d_free();
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((if_req || d_req || !m_idle || sb_q.size() != 0) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) fail("quiet_timeout", "traffic did not drain");
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_if_gnt"},   64'(if_gnt),   64'(0));
    check({tag, "_if_valid"}, 64'(if_valid), 64'(0));
    check({tag, "_d_gnt"},    64'(d_gnt),    64'(0));
    check({tag, "_d_valid"},  64'(d_valid),  64'(0));
    check({tag, "_mem_en"},   64'(mem_en),   64'(0));
    check({tag, "_mem_we"},   64'(mem_we),   64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"},64'(mem_wdata),64'(0));
    check({tag, "_rdata"},    64'(rdata),    64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    int d_edge, i_edge, n;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    s_if_req = 1'b0; s_if_addr = '0; s_d_req = 1'b0; s_d_we = 1'b0; s_d_addr = '0; s_d_wdata = '0;
    step(); step();
    check_main_zero("reset");
    check("reset_s_busy", 64'({s_if_gnt, s_if_valid, s_d_gnt, s_d_valid, s_mem_en, s_busy}), 64'(0));
    check("reset_s_rdata", 64'(s_rdata), 64'(0));
    rst_n = 1'b1;
    step();

    // Latency-1 fetch from word 0x005.
    s_if_addr = 10'h005; s_if_req = 1'b1;
    step();
    check("l1_if_gnt",   64'(s_if_gnt),   64'(1));
    check("l1_mem_en",   64'(s_mem_en),   64'(1));
    check("l1_mem_we",   64'(s_mem_we),   64'(0));
    check("l1_mem_addr", 64'(s_mem_addr), 64'(10'h005));
    check("l1_valid_early", 64'(s_if_valid), 64'(0));
    s_if_req = 1'b0;
    step();
    check("l1_if_valid", 64'(s_if_valid), 64'(1));
    check("l1_rdata",    64'(s_rdata),    64'(32'h2801_000A));
    check("l1_gnt_once", 64'(s_if_gnt),   64'(0));
    check("l1_busy_end", 64'(s_busy),     64'(0));
    step();
    check("l1_valid_once", 64'(s_if_valid), 64'(0));
    check("l1_rdata_hold", 64'(s_rdata),    64'(32'h2801_000A));

    // Simultaneous fetch and load: data first, fetch LAT+1 edges later.
    issue_fetch(10'h010);
    issue_data(1'b0, 10'h078, '0);
    d_edge = -1; i_edge = -1;
    for (int k = 0; k < 30 && i_edge < 0; k++) begin
      step();
      if (d_gnt && d_edge < 0) d_edge = edge_n;
      if (if_gnt && i_edge < 0) i_edge = edge_n;
    end
    check("prio_data_first", 64'(d_edge >= 0 && i_edge > d_edge), 64'(1));
    check("prio_gap", 64'(i_edge - d_edge), 64'(LAT + 1));
    wait_quiet();

    // Store, then read the stored word back.
    issue_data(1'b1, 10'h079, 32'h0000_0055);
    wait_quiet();
    issue_data(1'b0, 10'h079, '0);
    wait_quiet();

    // Data held continuously against one fetch.
    if_grants = 0; d_grants = 0; first_if_at = -1;
    issue_fetch(10'h033);
    d_hold = 1'b1;
    issue_data(1'b0, 10'h004, '0);
    for (int k = 0; k < 100 && d_grants < 8; k++) step();
    d_hold = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_fetch_once", 64'(if_grants), 64'(1));
    check("starve_after_n", 64'(first_if_at), 64'(STARVE_MAX));
`else
    check("strict_no_fetch", 64'(if_grants), 64'(0));
`endif
    wait_quiet();
    check("fetch_after_release", 64'(if_grants), 64'(1));

    // Reset in the middle of a load (counter at 1).
    issue_data(1'b0, 10'h020, '0);
    n = 0;
    while (!d_gnt && n < 20) begin step(); n++; end
    if (n >= 20) fail("rst_test_gnt", "load never granted");
    step();
    rst_n = 1'b0;
    #1;
    check_main_zero("midrst");
    step(); step();
    rst_n = 1'b1;
    step();
    issue_fetch(10'h007);
    wait_quiet();

    // Random traffic.
    rand_en = 1'b1;
    for (int k = 0; k < 600; k++) step();
    rand_en = 1'b0;
    wait_quiet();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 10, memory word-address width (1024-word Mem).
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..4.
REQ-004 clk1  in  1  single clock; all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-007 if_addr  in  AW  fetch word address (PC), stable while if_req high.
REQ-008 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-009 if_valid  out  1  one-cycle pulse: rdata holds fetched instruction.
REQ-010 d_req  in  1  data-stage (LW/SW) request, held until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load; stable with d_req.
REQ-012 d_addr  in  AW  data word address (ALU result).
REQ-013 d_wdata  in  DW  store data (B operand).
REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 d_valid  out  1  one-cycle pulse: load data in rdata, or store complete.
REQ-016 rdata  out  DW  read data for the requester pulsing valid.
REQ-017 mem_en  out  1  one-cycle memory access strobe.
REQ-018 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-019 mem_addr  out  AW  memory address, held for whole access.
REQ-020 mem_wdata  out  DW  memory write data, held for whole access.
REQ-021 mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
REQ-022 busy  out  1  high while an access is in flight (state ACCESS).

Function
REQ-023 FSM states: IDLE, ACCESS; one access in flight at a time.
REQ-024 IDLE, any req high at edge N: at edge N, grant winner (gnt=1 for one cycle), mem_en=1 for one cycle, latch addr/we/wdata into mem_*, cnt=0, go ACCESS.
REQ-025 Priority: d_req beats if_req. Simultaneous requests grant data; fetch stays pending.
REQ-026 ACCESS: cnt increments each edge; at edge where cnt==MEM_LAT-1, capture mem_rdata into rdata, pulse winner's valid, return IDLE.
REQ-027 Latency: grant at edge N, valid at edge N+MEM_LAT, earliest next grant at edge N+MEM_LAT+1.
REQ-028 Store: mem_we=1, d_valid pulses at N+MEM_LAT as write-complete; rdata unchanged.
REQ-029 Requests arriving during ACCESS are ignored until IDLE; req still high in IDLE is a new request.
REQ-030 gnt, valid, and mem_en never assert outside the cycles above; if_valid and d_valid never both high.
REQ-031 rdata retains last captured value between accesses.

Reset
REQ-032 rst_n low: state=IDLE, cnt=0, starvation count=0; if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy=0; mem_addr, mem_wdata, rdata=0.
REQ-033 Reset mid-ACCESS abandons access: no valid pulse; an issued memory write may complete.

Configuration
REQ-034 Macro MEM_ARB_STARVE_GUARD_EN: defined adds parameter STARVE_MAX (default 4) and a counter of consecutive IDLE arbitrations lost by a pending if_req; at STARVE_MAX, next arbitration grants fetch over data; counter clears on if grant or IDLE arbitration with if_req low.
REQ-035 Macro undefined: strict data-over-fetch priority, no counter logic.

Verification
REQ-036 MEM_LAT=1, if_req, if_addr=0x005, mem_rdata=0x2801000A -> if_gnt edge 1, if_valid and rdata=0x2801000A edge 2.
REQ-037 if_req and d_req (load 0x078) same edge -> d_gnt first, if_gnt at edge N+MEM_LAT+1; valids in same order.
REQ-038 d_req, d_we=1, d_addr=0x079, d_wdata=0x00000055 -> mem_en=mem_we=1 one cycle, mem_addr=0x079; d_valid after MEM_LAT; rdata unchanged.
REQ-039 MEM_LAT=3, rst_n low during ACCESS cnt=1 -> all outputs zero, no valid pulse; post-reset request served normally.
REQ-040 STARVE_GUARD_EN, STARVE_MAX=4, d_req and if_req held high -> data granted 4 times, 5th grant to fetch; undefined -> fetch never granted while d_req high.
